// File: rtl/matmul_arbiter.sv
// matmul_arbiter: round-robin arbiter sharing one matrix multiplier between
// two requesters. Each operation walks IDLE -> ISSUE -> WAIT -> RESP.
// Optional feature: define MATMUL_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYCLES cycles, answering with resp_err=1 and resp_data=0.
module matmul_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0,
   input  logic         req1,
   input  logic [255:0] a0,
   input  logic [255:0] b0,
   input  logic [255:0] a1,
   input  logic [255:0] b1,
   output logic         ack0,
   output logic         ack1,
   output logic [255:0] resp_data,
   output logic         resp_err,
   output logic         busy,
   output logic         mm_start,
   output logic [255:0] mm_a,
   output logic [255:0] mm_b,
   input  logic         mm_done,
   input  logic [255:0] mm_result
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t state;
   state_t state_next;
   logic   owner;        // requester being served: 0 or 1
   logic   last_served;  // requester that received the most recent ack
   logic   grant1;       // arbitration result in IDLE: 1 selects requester 1
   logic   timeout;

   // Round-robin pick: a lone request wins, a tie goes to whoever was not served last.
   always_comb begin
      grant1 = req1 & (~req0 | ~last_served);
   end

`ifdef MATMUL_TIMEOUT_EN
   localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] wait_cnt;
   logic          err_q;

   // Count cycles spent in WAIT; cleared whenever the FSM is elsewhere.
   always_ff @(posedge clk) begin
      if (rst)
         wait_cnt <= '0;
      else if (state == WAIT)
         wait_cnt <= wait_cnt + 1'b1;
      else
         wait_cnt <= '0;
   end

   // Abort when the final allowed WAIT cycle passes without mm_done.
   always_comb begin
      timeout = (state == WAIT) && !mm_done && (wait_cnt == CNT_LAST);
   end

   // Error flag reported alongside the ack of the current operation.
   always_ff @(posedge clk) begin
      if (rst)
         err_q <= 1'b0;
      else if (state == WAIT) begin
         if (mm_done)
            err_q <= 1'b0;
         else if (timeout)
            err_q <= 1'b1;
      end
   end
`else
   // Without the timeout feature WAIT only ends on mm_done.
   always_comb begin
      timeout = 1'b0;
   end
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state logic; mm_done only matters in WAIT.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (req0 || req1) state_next = ISSUE;
         ISSUE:   state_next = WAIT;
         WAIT:    if (mm_done || timeout) state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: latch operands at grant, capture result, advance the round-robin pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner       <= 1'b0;
         last_served <= 1'b1;
         mm_a        <= '0;
         mm_b        <= '0;
         resp_data   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  owner <= grant1;
                  mm_a  <= grant1 ? a1 : a0;
                  mm_b  <= grant1 ? b1 : b0;
               end
            end
            WAIT: begin
               if (mm_done)
                  resp_data <= mm_result;
               else if (timeout)
                  resp_data <= '0;
            end
            RESP:    last_served <= owner;
            default: ;
         endcase
      end
   end

   // Moore outputs decoded from the state and the recorded owner.
   always_comb begin
      busy     = (state != IDLE);
      mm_start = (state == ISSUE);
      ack0     = (state == RESP) && !owner;
      ack1     = (state == RESP) && owner;
`ifdef MATMUL_TIMEOUT_EN
      resp_err = err_q;
`else
      resp_err = 1'b0;
`endif
   end

endmodule

// File: tb/tb_matmul_arbiter.sv
// Scoreboard bench for matmul_arbiter: stimulus pushes expected acks and
// mm_start cycles into queues; a monitor pops and compares on every pulse.
module tb_matmul_arbiter;

   localparam int TO = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req0 = 1'b0, req1 = 1'b0;
   logic [255:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic         mm_done = 1'b0;
   logic [255:0] mm_result = '0;
   logic         ack0, ack1, resp_err, busy, mm_start;
   logic [255:0] resp_data, mm_a, mm_b;

   always #5 clk = ~clk;

   matmul_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .ack0(ack0), .ack1(ack1), .resp_data(resp_data), .resp_err(resp_err),
      .busy(busy), .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b),
      .mm_done(mm_done), .mm_result(mm_result)
   );

   typedef struct {
      bit           line;
      logic [255:0] data;
      bit           err;
      int           cyc;
   } exp_t;

   exp_t exp_q[$];
   int   st_q[$];
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   int   acks_seen = 0;
   bit   auto_en = 1'b1;
   bit   manual_done = 1'b0;
   bit   prev_start = 1'b0;

   localparam logic [255:0] D_0F   = {32{8'h0F}};
   localparam logic [255:0] A0_PAT = {8{32'hF0F0_F0F0}};
   localparam logic [255:0] B0_PAT = {8{32'hFF00_FF00}};
   localparam logic [255:0] R0_PAT = {8{32'hF000_F000}};
   localparam logic [255:0] A1_PAT = {8{32'h1234_5678}};
   localparam logic [255:0] B1_PAT = {8{32'h0F0F_0F0F}};
   localparam logic [255:0] R1_PAT = {8{32'h0204_0608}};

   task automatic chk_w(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_i(input string nm, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic push_ack(input bit line, input logic [255:0] data, input bit err, input int c);
      exp_t e;
      e.line = line; e.data = data; e.err = err; e.cyc = c;
      exp_q.push_back(e);
   endtask

   task automatic wait_acks(input int target, input int budget);
      int b;
      b = budget;
      while (acks_seen < target && b > 0) begin
         @(negedge clk); #1;
         b--;
      end
      if (acks_seen < target) begin
         n_vec++; n_err++;
         $display("FAIL ack_timeout: got %0d acks expected %0d", acks_seen, target);
      end
   endtask

   // Edge counter: cyc = number of rising edges seen so far.
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Multiplier stand-in: done one cycle after start, result = mm_a & mm_b.
   initial forever begin
      @(negedge clk); #2;
      mm_done    = auto_en ? prev_start : manual_done;
      prev_start = mm_start;
      mm_result  = mm_a & mm_b;
   end

   // Monitor: pops the scoreboard on every ack and every mm_start.
   initial begin : monitor
      exp_t e;
      int   sc;
      forever begin
         @(negedge clk);
         if (ack0 && ack1) begin
            n_vec++; n_err++;
            $display("FAIL ack_both: got ack0=1 ack1=1 expected at most one");
         end
         if (ack0 || ack1) begin
            acks_seen++;
            if (exp_q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL unexpected_ack: got ack0=%0b ack1=%0b at cycle %0d expected none", ack0, ack1, cyc);
            end else begin
               e = exp_q.pop_front();
               chk_i("ack_line", int'(ack1), int'(e.line));
               chk_w("resp_data", resp_data, e.data);
               chk_i("resp_err", int'(resp_err), int'(e.err));
               chk_i("ack_cycle", cyc, e.cyc);
            end
         end
         if (mm_start) begin
            if (st_q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL unexpected_start: got mm_start=1 at cycle %0d expected 0", cyc);
            end else begin
               sc = st_q.pop_front();
               chk_i("start_cycle", cyc, sc);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      n_err++;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state.
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk_i("rst_busy", int'(busy), 0);
      chk_i("rst_ack0", int'(ack0), 0);
      chk_i("rst_ack1", int'(ack1), 0);
      chk_i("rst_mm_start", int'(mm_start), 0);
      chk_i("rst_resp_err", int'(resp_err), 0);
      chk_w("rst_resp_data", resp_data, '0);
      chk_w("rst_mm_a", mm_a, '0);
      chk_w("rst_mm_b", mm_b, '0);
      rst = 1'b0;

      // Stray done in IDLE with no request.
      auto_en = 1'b0;
      manual_done = 1'b1;
      repeat (2) @(negedge clk);
      manual_done = 1'b0;
      repeat (2) @(negedge clk);
      chk_i("stray_busy", int'(busy), 0);
      chk_w("stray_resp_data", resp_data, '0);
      auto_en = 1'b1;

      // Single op from requester 0; operands change right after grant.
      req0 = 1'b1; a0 = '1; b0 = D_0F;
      st_q.push_back(cyc + 1);
      push_ack(1'b0, D_0F, 1'b0, cyc + 3);
      @(negedge clk);
      a0 = '0; b0 = '0;
      chk_i("single_busy", int'(busy), 1);
      wait_acks(1, 20);
      req0 = 1'b0;
      repeat (3) @(negedge clk);
      chk_i("single_idle", int'(busy), 0);

      // Contention from reset: both held for three ops, order 0,1,0.
      rst = 1'b1;
      req0 = 1'b1; req1 = 1'b1;
      a0 = A0_PAT; b0 = B0_PAT; a1 = A1_PAT; b1 = B1_PAT;
      @(negedge clk);
      rst = 1'b0;
      st_q.push_back(cyc + 1);
      st_q.push_back(cyc + 5);
      st_q.push_back(cyc + 9);
      push_ack(1'b0, R0_PAT, 1'b0, cyc + 3);
      push_ack(1'b1, R1_PAT, 1'b0, cyc + 7);
      push_ack(1'b0, R0_PAT, 1'b0, cyc + 11);
      wait_acks(4, 40);
      req0 = 1'b0; req1 = 1'b0;
      repeat (2) @(negedge clk);

      // Early drop: req1 held for one cycle only.
      req1 = 1'b1;
      st_q.push_back(cyc + 1);
      push_ack(1'b1, R1_PAT, 1'b0, cyc + 3);
      @(negedge clk);
      req1 = 1'b0;
      wait_acks(5, 20);
      repeat (6) @(negedge clk);
      chk_i("drop_idle", int'(busy), 0);

      // Reset in WAIT, then a late mm_done.
      auto_en = 1'b0; manual_done = 1'b0;
      req0 = 1'b1; a0 = '1; b0 = '1;
      st_q.push_back(cyc + 1);
      @(negedge clk);
      @(negedge clk);
      chk_i("wait_busy", int'(busy), 1);
      rst = 1'b1; req0 = 1'b0;
      @(negedge clk);
      rst = 1'b0; manual_done = 1'b1;
      repeat (2) @(negedge clk);
      manual_done = 1'b0;
      repeat (3) @(negedge clk);
      chk_i("rstwait_busy", int'(busy), 0);
      chk_w("rstwait_resp_data", resp_data, '0);
      chk_i("rstwait_noack", acks_seen, 5);

`ifdef MATMUL_TIMEOUT_EN
      // Timeout: mm_done never arrives.
      req1 = 1'b1;
      st_q.push_back(cyc + 1);
      push_ack(1'b1, '0, 1'b1, cyc + 1 + TO + 1);
      wait_acks(6, 40);
      req1 = 1'b0;
      repeat (2) @(negedge clk);
      chk_i("timeout_idle", int'(busy), 0);
`else
      // No timeout: WAIT holds until mm_done, however long.
      req1 = 1'b1;
      st_q.push_back(cyc + 1);
      @(negedge clk);
      req1 = 1'b0;
      repeat (20) @(negedge clk);
      chk_i("long_wait_busy", int'(busy), 1);
      manual_done = 1'b1;
      push_ack(1'b1, R1_PAT, 1'b0, cyc + 1);
      @(negedge clk);
      manual_done = 1'b0;
      wait_acks(6, 20);
      repeat (2) @(negedge clk);
      chk_i("long_wait_idle", int'(busy), 0);
`endif

      chk_i("ack_queue_empty", exp_q.size(), 0);
      chk_i("start_queue_empty", st_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/matmul_arbiter.md
MATMUL_ARBITER -- requirements
Module: matmul_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 64, max WAIT-state cycles before abort (used only with MATMUL_TIMEOUT_EN).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0 / req1  input  1 each  operation request from requester 0 / 1; held until the matching ack.
REQ-005 a0, b0 / a1, b1  input  256 each  operand matrices from requester 0 / 1; sampled only at grant.
REQ-006 ack0 / ack1  output  1 each  one-cycle completion pulse to requester 0 / 1.
REQ-007 resp_data  output  256  result; valid only while ack0 or ack1 is high.
REQ-008 resp_err  output  1  timeout flag; valid only while ack0 or ack1 is high.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 mm_start  output  1  start pulse to the matrix multiplier.
REQ-011 mm_a, mm_b  output  256 each  registered operands to the multiplier.
REQ-012 mm_done  input  1  multiplier completion.
REQ-013 mm_result  input  256  multiplier result; sampled when mm_done=1 in WAIT.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE, WAIT and RESP.
REQ-015 IDLE: if any req is high, the block SHALL grant one requester, latch its operands into mm_a/mm_b, record the owner, and go to ISSUE.
REQ-016 Arbitration SHALL be round-robin: with both req high, grant the requester not served last; a lone request is granted immediately.
REQ-017 ISSUE: mm_start SHALL be high for exactly this one cycle; next state WAIT.
REQ-018 WAIT: on mm_done=1, the block SHALL capture mm_result into resp_data and go to RESP.
REQ-019 RESP: ack of the owner only SHALL be high for one cycle, resp_err=0 unless timed out, last-served pointer updated; next state IDLE.
REQ-020 Latency with a multiplier that raises done one cycle after start: ack SHALL be high on the 4th cycle after the req-sampling edge (IDLE, ISSUE, WAIT, RESP = 4 cycles per op).
REQ-021 A req still held in IDLE after RESP SHALL be re-arbitrated normally; a back-to-back stream SHALL alternate when both requesters are active.
REQ-022 A req dropped before its ack SHALL NOT abort the operation; the ack SHALL still be issued.
REQ-023 mm_done in IDLE, ISSUE or RESP SHALL be ignored.
REQ-024 Operand changes on a0/b0/a1/b1 after grant SHALL NOT affect mm_a/mm_b.
REQ-025 ack0 and ack1 SHALL never be high in the same cycle.

Reset
REQ-026 While rst=1, at the next edge: state IDLE; ack0, ack1, mm_start, resp_err, busy = 0; resp_data, mm_a, mm_b = 0; last-served pointer = requester 1, so requester 0 wins the first tie.
REQ-027 Reset mid-operation SHALL abandon the operation without any ack; a later mm_done SHALL be ignored.

Configuration
REQ-028 Macro MATMUL_TIMEOUT_EN defined: a WAIT cycle counter SHALL run; when it reaches TIMEOUT_CYCLES without mm_done, the FSM SHALL go to RESP with resp_err=1 and resp_data=0.
REQ-029 Macro MATMUL_TIMEOUT_EN undefined: no counter; WAIT SHALL last until mm_done; resp_err is tied to 0.

Verification
REQ-030 Single op: req0=1, a0=all-ones, b0=0x0F repeated, multiplier asserts done one cycle after start -> exactly one ack0 pulse on the 4th cycle, resp_data=0x0F repeated, ack1 stays 0.
REQ-031 Contention: req0 and req1 high together from reset, held for 3 ops -> grant order 0,1,0; one-cycle mm_start per op; acks 4 cycles apart.
REQ-032 Early drop: req1 pulsed for 1 cycle only -> mm_start still asserted once, ack1 still delivered, no second op.
REQ-033 Reset mid-WAIT: rst in WAIT, then mm_done pulsed -> no ack, busy=0, state IDLE.
REQ-034 Timeout (MATMUL_TIMEOUT_EN, TIMEOUT_CYCLES=8): mm_done held 0 -> ack on the correct line with resp_err=1, resp_data=0, FSM back in IDLE.
REQ-035 Stray done: mm_done pulsed while IDLE with no req -> no ack, state unchanged.
